// File: rtl/mem_arbiter.sv
// Round-robin arbiter between an instruction-fetch port and a data port sharing one memory bus,
// with a memory-mapped LED register and alignment checking on the data port.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] LED_ADDR    = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_len,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        m_rw,
    output logic [1:0]  m_len,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic [7:0]  led
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

    localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        prio_d_q, prio_d_d;
    logic        sel_d_q, sel_d_d;
    logic        rw_q, rw_d;
    logic        led_hit_q, led_hit_d;
    logic [1:0]  m_len_q, m_len_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        d_err_q, d_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [7:0]  led_q, led_d;

    logic        d_bad;
    logic        i_bad;
    logic        grant_d;
    logic        grant_i;
    logic [31:0] rd_lane;

    always_comb begin
        d_bad = 1'b1;
        unique case (d_len)
            2'b00:   d_bad = 1'b0;
            2'b01:   d_bad = d_addr[0];
            2'b10:   d_bad = |d_addr[1:0];
            default: d_bad = 1'b1;
        endcase
    end

    assign i_bad   = |i_addr[1:0];
    assign grant_d = d_req && (!i_req || prio_d_q);
    assign grant_i = i_req && !grant_d;

    // Zero-extend the addressed lane of the memory word for sub-word reads.
    always_comb begin
        rd_lane = m_rdata;
        unique case (m_len_q)
            2'b00: begin
                unique case (m_addr_q[1:0])
                    2'b00:   rd_lane = {24'b0, m_rdata[7:0]};
                    2'b01:   rd_lane = {24'b0, m_rdata[15:8]};
                    2'b10:   rd_lane = {24'b0, m_rdata[23:16]};
                    default: rd_lane = {24'b0, m_rdata[31:24]};
                endcase
            end
            2'b01:   rd_lane = m_addr_q[1] ? {16'b0, m_rdata[31:16]} : {16'b0, m_rdata[15:0]};
            default: rd_lane = m_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d_d  = prio_d_q;
        sel_d_d   = sel_d_q;
        rw_d      = rw_q;
        led_hit_d = led_hit_q;
        m_len_d   = m_len_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        led_d     = led_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        d_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (grant_d) begin
                    sel_d_d = 1'b1;
                    if (d_bad) begin
                        // Rejected transfers never touch the memory bus.
                        state_d   = StDone;
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = 32'd0;
                    end else begin
                        state_d   = StBusyD;
                        rw_d      = d_rw;
                        led_hit_d = (d_addr == LED_ADDR);
                        m_len_d   = d_len;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end
                end else if (grant_i) begin
                    sel_d_d = 1'b0;
                    if (i_bad) begin
                        state_d   = StDone;
                        i_ack_d   = 1'b1;
                        i_rdata_d = 32'd0;
                    end else begin
                        state_d  = StBusyI;
                        m_len_d  = 2'b10;
                        m_addr_d = i_addr;
                    end
                end
            end
            StBusyI: begin
                if (cnt_q == WaitLast) begin
                    state_d   = StDone;
                    cnt_d     = 4'd0;
                    i_ack_d   = 1'b1;
                    i_rdata_d = m_rdata;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StBusyD: begin
                if (led_hit_q) begin
                    state_d = StDone;
                    d_ack_d = 1'b1;
                    if (rw_q) begin
                        led_d     = m_wdata_q[7:0];
                        d_rdata_d = 32'd0;
                    end else begin
                        d_rdata_d = {24'b0, led_q};
                    end
                end else if (cnt_q == WaitLast) begin
                    state_d   = StDone;
                    cnt_d     = 4'd0;
                    d_ack_d   = 1'b1;
                    d_rdata_d = rw_q ? 32'd0 : rd_lane;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d  = StIdle;
                prio_d_d = !sel_d_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            prio_d_q  <= 1'b1;
            sel_d_q   <= 1'b0;
            rw_q      <= 1'b0;
            led_hit_q <= 1'b0;
            m_len_q   <= 2'b00;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            led_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_d_q  <= prio_d_d;
            sel_d_q   <= sel_d_d;
            rw_q      <= rw_d;
            led_hit_q <= led_hit_d;
            m_len_q   <= m_len_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            led_q     <= led_d;
        end
    end

    // Acks are suppressed while reset is held so an aborted transfer in DONE is never acknowledged.
    assign i_ack   = i_ack_q && !rst;
    assign d_ack   = d_ack_q && !rst;
    assign d_err   = d_err_q && !rst;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign m_rw    = (state_q == StBusyD) && rw_q && !led_hit_q;
    assign m_len   = m_len_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign led     = led_q;

endmodule
